// File: rtl/pipe_stage_latch.sv
// pipe_stage_latch: inter-stage pipeline register with valid, flush-to-bubble and a multi-cycle stall counter; define PIPE_STAGE_LATCH_PERF_EN to add hold/flush performance counters
module pipe_stage_latch #(
  parameter int DATA_W      = 128,
  parameter int CTRL_W      = 23,
  parameter int RD_W        = 4,
  parameter int STALL_CNT_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [RD_W-1:0]        in_rd,
  input  logic                   stall,
  input  logic                   stall_load,
  input  logic [STALL_CNT_W-1:0] stall_cycles,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [RD_W-1:0]        out_rd,
  output logic                   busy
`ifdef PIPE_STAGE_LATCH_PERF_EN
  ,
  output logic [15:0]            perf_hold_cnt,
  output logic [15:0]            perf_flush_cnt
`endif
);
  logic [STALL_CNT_W-1:0] cnt;
  logic ld_hold, hold;
  assign ld_hold = stall_load & (stall_cycles != '0);
  assign hold    = stall | ld_hold | (cnt != '0);
  assign busy    = cnt != '0;
  // stage register: reset > flush (bubble, keep data/rd) > hold > capture; a reload replaces the count
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
      out_rd    <= '0;
      cnt       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      cnt       <= '0;
    end else begin
      if (!hold) begin
        out_valid <= in_valid;
        out_data  <= in_data;
        out_rd    <= in_rd;
        out_ctrl  <= in_valid ? in_ctrl : '0;
      end
      cnt <= ld_hold ? stall_cycles - 1'b1 : busy ? cnt - 1'b1 : cnt;
    end
  end
`ifdef PIPE_STAGE_LATCH_PERF_EN
  // saturating event counters for held and flushed edges
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_hold_cnt  <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (hold && !flush && perf_hold_cnt != 16'hFFFF) perf_hold_cnt <= perf_hold_cnt + 16'd1;
      if (flush && perf_flush_cnt != 16'hFFFF) perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_latch.sv
// tb_pipe_stage_latch: directed and randomized checks of pipe_stage_latch against a behavioural model
module tb_pipe_stage_latch;
  logic         clk = 0;
  logic         reset = 0;
  logic         in_valid = 0;
  logic [127:0] in_data = '0;
  logic [22:0]  in_ctrl = '0;
  logic [3:0]   in_rd = '0;
  logic         stall = 0;
  logic         stall_load = 0;
  logic [1:0]   stall_cycles = '0;
  logic         flush = 0;
  logic         out_valid;
  logic [127:0] out_data;
  logic [22:0]  out_ctrl;
  logic [3:0]   out_rd;
  logic         busy;
`ifdef PIPE_STAGE_LATCH_PERF_EN
  logic [15:0]  perf_hold_cnt, perf_flush_cnt;
`endif
  int errors = 0, checks = 0;
  logic         m_valid = 0;
  logic [127:0] m_data = '0;
  logic [22:0]  m_ctrl = '0;
  logic [3:0]   m_rd = '0;
  int           m_frozen = 0;
  int           m_ph = 0, m_pf = 0;

  pipe_stage_latch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
    .in_rd(in_rd), .stall(stall), .stall_load(stall_load), .stall_cycles(stall_cycles),
    .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_ctrl(out_ctrl),
    .out_rd(out_rd), .busy(busy)
`ifdef PIPE_STAGE_LATCH_PERF_EN
    , .perf_hold_cnt(perf_hold_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // m_frozen counts the edges still to be frozen after the current one
  task automatic model();
    bit frz;
    if (!reset) begin
      m_valid = 0; m_data = '0; m_ctrl = '0; m_rd = '0; m_frozen = 0; m_ph = 0; m_pf = 0;
    end else if (flush) begin
      m_valid = 0; m_ctrl = '0; m_frozen = 0;
      if (m_pf < 65535) m_pf++;
    end else begin
      frz = stall || (stall_load && stall_cycles != 0) || m_frozen > 0;
      if (frz && m_ph < 65535) m_ph++;
      if (!frz) begin
        m_valid = in_valid; m_data = in_data; m_rd = in_rd;
        m_ctrl = in_valid ? in_ctrl : '0;
      end
      if (stall_load && stall_cycles != 0) m_frozen = int'(stall_cycles) - 1;
      else if (m_frozen > 0) m_frozen--;
    end
  endtask

  task automatic step();
    model();
    @(posedge clk);
    #1;
    chk("valid", out_valid, m_valid);
    chk("data", out_data, m_data);
    chk("ctrl", out_ctrl, m_ctrl);
    chk("rd", out_rd, m_rd);
    chk("busy", busy, m_frozen > 0);
`ifdef PIPE_STAGE_LATCH_PERF_EN
    chk("perf_hold", perf_hold_cnt, m_ph[15:0]);
    chk("perf_flush", perf_flush_cnt, m_pf[15:0]);
`endif
  endtask

  task automatic drive(input logic v, input logic [127:0] d, input logic [22:0] c, input logic [3:0] r);
    in_valid = v; in_data = d; in_ctrl = c; in_rd = r;
  endtask

  initial begin
    #2;
    reset = 0;
    drive(1, '1, '1, 4'hF);
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    reset = 1;
    drive(1, 128'h1234, 23'h1, 4'd5);
    step();
    chk("cap_data", out_data, 128'h1234);
    chk("cap_rd", out_rd, 5);
    chk("cap_valid", out_valid, 1);
    drive(1, 1, 0, 1); step();
    chk("s1", out_data, 1);
    drive(1, 2, 0, 1); stall = 1; step();
    chk("s2", out_data, 1);
    stall = 0; step();
    chk("s3", out_data, 2);
    drive(1, 3, 0, 1); step();
    chk("s4", out_data, 3);
    stall_load = 1; stall_cycles = 3; drive(1, 10, 0, 2); step();
    stall_load = 0;
    chk("m1_data", out_data, 3);
    chk("m1_busy", busy, 1);
    drive(1, 11, 0, 2); step();
    chk("m2_busy", busy, 1);
    drive(1, 12, 0, 2); step();
    chk("m3_data", out_data, 3);
    chk("m3_busy", busy, 0);
    drive(1, 13, 0, 2); step();
    chk("m4_data", out_data, 13);
    stall_load = 1; stall_cycles = 3; drive(1, 20, 23'h55, 3); step();
    stall_load = 0;
    chk("f0_busy", busy, 1);
    flush = 1; stall = 1; drive(1, 21, 23'h55, 3); step();
    flush = 0; stall = 0;
    chk("f1_valid", out_valid, 0);
    chk("f1_ctrl", out_ctrl, 0);
    chk("f1_data", out_data, 13);
    chk("f1_busy", busy, 0);
    drive(1, 22, 23'h55, 3); step();
    chk("f2_data", out_data, 22);
    drive(0, 128'hABC, '1, 7); step();
    chk("b_valid", out_valid, 0);
    chk("b_ctrl", out_ctrl, 0);
    chk("b_data", out_data, 128'hABC);
    drive(1, 30, 1, 1);
    stall_load = 1; stall_cycles = 3; step();
    stall_cycles = 2; drive(1, 31, 1, 1); step();
    stall_load = 0; drive(1, 32, 1, 1); step();
    chk("r3_data", out_data, 128'hABC);
    drive(1, 33, 1, 1); step();
    chk("r4_data", out_data, 33);
    stall_load = 1; stall_cycles = 0; drive(1, 34, 1, 1); step();
    stall_load = 0;
    chk("z_data", out_data, 34);
`ifdef PIPE_STAGE_LATCH_PERF_EN
    reset = 0; step(); reset = 1;
    stall = 1; repeat (4) step();
    stall = 0; flush = 1; repeat (2) step();
    flush = 0;
    chk("perf4", perf_hold_cnt, 4);
    chk("perf2", perf_flush_cnt, 2);
    reset = 0; step(); reset = 1;
    chk("perf_clr", perf_hold_cnt, 0);
`endif
    for (int i = 0; i < 600; i++) begin
      reset = $urandom_range(0, 49) != 0;
      flush = $urandom_range(0, 9) == 0;
      stall = $urandom_range(0, 4) == 0;
      stall_load = $urandom_range(0, 5) == 0;
      stall_cycles = 2'($urandom_range(0, 3));
      drive(1'($urandom), {$urandom, $urandom, $urandom, $urandom}, 23'($urandom), 4'($urandom));
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
